axil_decerr_slave: RTL and testbench

- AXI-Lite default slave for the interconnect; receives every transaction whose address matches no slave window.
- Completes the full AXI-Lite handshake and answers with DECERR, so masters never hang on unmapped addresses.
- Keeps sticky error counters and captures the last offending address for debug and status registers.

---
 rtl/axil_decerr_slave_if.sv | 38 +++
 rtl/axil_decerr_slave.sv | 92 +++++++++
 tb/tb_axil_decerr_slave.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/axil_decerr_slave_if.sv
// AXI-Lite bus bundle for the decode-error slave.
// The slave modport is the block side; the master modport is the interconnect or bench side.
interface axil_decerr_slave_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   s_awaddr;
    logic                    s_awvalid;
    logic                    s_awready;
    logic [DATA_WIDTH-1:0]   s_wdata;
    logic [DATA_WIDTH/8-1:0] s_wstrb;
    logic                    s_wvalid;
    logic                    s_wready;
    logic [1:0]              s_bresp;
    logic                    s_bvalid;
    logic                    s_bready;
    logic [ADDR_WIDTH-1:0]   s_araddr;
    logic                    s_arvalid;
    logic                    s_arready;
    logic [DATA_WIDTH-1:0]   s_rdata;
    logic [1:0]              s_rresp;
    logic                    s_rvalid;
    logic                    s_rready;

    modport slave (
        input  s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
        input  s_araddr, s_arvalid, s_rready,
        output s_awready, s_wready, s_bresp, s_bvalid,
        output s_arready, s_rdata, s_rresp, s_rvalid
    );

    modport master (
        output s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
        output s_araddr, s_arvalid, s_rready,
        input  s_awready, s_wready, s_bresp, s_bvalid,
        input  s_arready, s_rdata, s_rresp, s_rvalid
    );
endinterface

// File: rtl/axil_decerr_slave.sv
// Default AXI-Lite slave: it completes every transaction with DECERR.
// It also keeps saturating error counters and the last offending address for status registers.
module axil_decerr_slave #(
    parameter int          ADDR_WIDTH = 32,
    parameter int          DATA_WIDTH = 32,
    parameter logic [31:0] ERR_DATA   = 32'hDEAD_BEEF,
    parameter int          COUNT_W    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    axil_decerr_slave_if.slave    s,
    output logic [COUNT_W-1:0]    err_wr_count,
    output logic [COUNT_W-1:0]    err_rd_count,
    output logic [ADDR_WIDTH-1:0] last_err_addr
);
    localparam logic [1:0] RESP_DECERR = 2'b11;

    logic aw_done, w_done;
    logic aw_hs, w_hs, ar_hs, wr_complete;

    // The write data payload is accepted and discarded.
    logic unused_wpayload;
    assign unused_wpayload = ^{s.s_wdata, s.s_wstrb};

    // The readies are state-only, so they never wait on valid. They are held low during reset.
    assign s.s_awready = !rst && !aw_done && !s.s_bvalid;
    assign s.s_wready  = !rst && !w_done  && !s.s_bvalid;
    assign s.s_arready = !rst && !s.s_rvalid;

    assign aw_hs       = s.s_awvalid && s.s_awready;
    assign w_hs        = s.s_wvalid  && s.s_wready;
    assign ar_hs       = s.s_arvalid && s.s_arready;
    assign wr_complete = (aw_done || aw_hs) && (w_done || w_hs);

    always_ff @(posedge clk) begin
        if (rst) begin
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            s.s_bvalid <= 1'b0;
            s.s_bresp  <= 2'b00;
        end else begin
            if (s.s_bvalid && s.s_bready) begin
                s.s_bvalid <= 1'b0;
                s.s_bresp  <= 2'b00;
            end
            // Completion cannot coincide with a B handshake: both readies are low while bvalid is high.
            if (wr_complete) begin
                s.s_bvalid <= 1'b1;
                s.s_bresp  <= RESP_DECERR;
                aw_done    <= 1'b0;
                w_done     <= 1'b0;
            end else begin
                if (aw_hs) aw_done <= 1'b1;
                if (w_hs)  w_done  <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s.s_rvalid <= 1'b0;
            s.s_rresp  <= 2'b00;
            s.s_rdata  <= '0;
        end else if (ar_hs) begin
            s.s_rvalid <= 1'b1;
            s.s_rresp  <= RESP_DECERR;
            s.s_rdata  <= DATA_WIDTH'(ERR_DATA);
        end else if (s.s_rvalid && s.s_rready) begin
            s.s_rvalid <= 1'b0;
            s.s_rresp  <= 2'b00;
            s.s_rdata  <= '0;
        end
    end

    // Each counter steps on the cycle its response is launched.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_wr_count  <= '0;
            err_rd_count  <= '0;
            last_err_addr <= '0;
        end else begin
            if (wr_complete && err_wr_count != '1)
                err_wr_count <= err_wr_count + COUNT_W'(1);
            if (ar_hs && err_rd_count != '1)
                err_rd_count <= err_rd_count + COUNT_W'(1);
            if (aw_hs)
                last_err_addr <= s.s_awaddr;
            else if (ar_hs)
                last_err_addr <= s.s_araddr;
        end
    end
endmodule

// File: tb/tb_axil_decerr_slave.sv
// Directed bench for axil_decerr_slave: the default instance plus a COUNT_W=2 instance for saturation.
// Inputs change and outputs are sampled 1 time unit after each rising clock edge.
module tb_axil_decerr_slave;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst2 = 1'b1;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    axil_decerr_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();
    axil_decerr_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus2 ();

    logic [15:0] wr_cnt, rd_cnt;
    logic [31:0] last_addr;
    logic [1:0]  wr_cnt2, rd_cnt2;
    logic [31:0] last_addr2;

    axil_decerr_slave dut (
        .clk(clk), .rst(rst), .s(bus.slave),
        .err_wr_count(wr_cnt), .err_rd_count(rd_cnt), .last_err_addr(last_addr)
    );

    axil_decerr_slave #(.COUNT_W(2)) dut2 (
        .clk(clk), .rst(rst2), .s(bus2.slave),
        .err_wr_count(wr_cnt2), .err_rd_count(rd_cnt2), .last_err_addr(last_addr2)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        bus.s_awaddr = '0; bus.s_awvalid = 0; bus.s_wdata = 32'h1234_5678; bus.s_wstrb = 4'hF;
        bus.s_wvalid = 0; bus.s_bready = 0; bus.s_araddr = '0; bus.s_arvalid = 0; bus.s_rready = 0;
        bus2.s_awaddr = '0; bus2.s_awvalid = 0; bus2.s_wdata = '0; bus2.s_wstrb = '0;
        bus2.s_wvalid = 0; bus2.s_bready = 0; bus2.s_araddr = '0; bus2.s_arvalid = 0; bus2.s_rready = 0;

        // Reset is held for three edges.
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("rst_awready", bus.s_awready, 0);
            chk("rst_wready", bus.s_wready, 0);
            chk("rst_arready", bus.s_arready, 0);
        end
        rst = 0; rst2 = 0;
        #1;
        chk("rel_awready", bus.s_awready, 1);
        chk("rel_wready", bus.s_wready, 1);
        chk("rel_arready", bus.s_arready, 1);
        chk("rel_bvalid", bus.s_bvalid, 0);
        chk("rel_rvalid", bus.s_rvalid, 0);
        chk("rel_rdata", bus.s_rdata, 0);
        chk("rel_wrcnt", wr_cnt, 0);
        chk("rel_rdcnt", rd_cnt, 0);
        chk("rel_last", last_addr, 0);

        // Write with AW and W in the same cycle.
        bus.s_awaddr = 32'h0000_5000; bus.s_awvalid = 1; bus.s_wvalid = 1; bus.s_bready = 1;
        cyc();
        bus.s_awvalid = 0; bus.s_wvalid = 0;
        chk("w1_bvalid", bus.s_bvalid, 1);
        chk("w1_bresp", bus.s_bresp, 2'b11);
        chk("w1_wrcnt", wr_cnt, 1);
        chk("w1_last", last_addr, 32'h0000_5000);
        chk("w1_awready_busy", bus.s_awready, 0);
        cyc();
        chk("w1_bvalid_done", bus.s_bvalid, 0);
        chk("w1_awready_back", bus.s_awready, 1);
        chk("w1_wready_back", bus.s_wready, 1);

        // W three cycles before AW, with bready held low for four cycles.
        bus.s_bready = 0; bus.s_wvalid = 1;
        cyc();
        bus.s_wvalid = 0;
        chk("w2_wready_drop", bus.s_wready, 0);
        chk("w2_awready_open", bus.s_awready, 1);
        chk("w2_no_bvalid", bus.s_bvalid, 0);
        cyc();
        cyc();
        chk("w2_still_no_bvalid", bus.s_bvalid, 0);
        bus.s_awaddr = 32'h0000_6004; bus.s_awvalid = 1;
        cyc();
        bus.s_awvalid = 0;
        for (int i = 0; i < 4; i++) begin
            chk("w2_bvalid_hold", bus.s_bvalid, 1);
            chk("w2_bresp_hold", bus.s_bresp, 2'b11);
            chk("w2_awready_low", bus.s_awready, 0);
            chk("w2_wready_low", bus.s_wready, 0);
            if (i < 3) cyc();
        end
        chk("w2_wrcnt", wr_cnt, 2);
        chk("w2_last", last_addr, 32'h0000_6004);
        bus.s_bready = 1;
        cyc();
        chk("w2_bvalid_done", bus.s_bvalid, 0);
        chk("w2_awready_back", bus.s_awready, 1);
        chk("w2_wready_back", bus.s_wready, 1);
        chk("w2_wrcnt_after", wr_cnt, 2);

        // Read with rready held low for two cycles.
        bus.s_araddr = 32'h0000_7000; bus.s_arvalid = 1; bus.s_rready = 0;
        cyc();
        bus.s_arvalid = 0;
        for (int i = 0; i < 2; i++) begin
            chk("r1_rvalid", bus.s_rvalid, 1);
            chk("r1_rdata", bus.s_rdata, 32'hDEAD_BEEF);
            chk("r1_rresp", bus.s_rresp, 2'b11);
            chk("r1_arready_low", bus.s_arready, 0);
            if (i < 1) cyc();
        end
        chk("r1_rdcnt", rd_cnt, 1);
        chk("r1_last", last_addr, 32'h0000_7000);
        bus.s_rready = 1;
        cyc();
        chk("r1_rvalid_done", bus.s_rvalid, 0);
        chk("r1_rdata_zero", bus.s_rdata, 0);
        chk("r1_arready_back", bus.s_arready, 1);

        // Concurrent AW+W and AR: the write address wins last_err_addr.
        bus.s_awaddr = 32'h8000_0000; bus.s_awvalid = 1; bus.s_wvalid = 1;
        bus.s_araddr = 32'h9000_0000; bus.s_arvalid = 1;
        cyc();
        bus.s_awvalid = 0; bus.s_wvalid = 0; bus.s_arvalid = 0;
        chk("c_bvalid", bus.s_bvalid, 1);
        chk("c_rvalid", bus.s_rvalid, 1);
        chk("c_last", last_addr, 32'h8000_0000);
        chk("c_wrcnt", wr_cnt, 3);
        chk("c_rdcnt", rd_cnt, 2);
        cyc();
        chk("c_bvalid_done", bus.s_bvalid, 0);
        chk("c_rvalid_done", bus.s_rvalid, 0);

        // A 2-bit read counter saturates at 3.
        bus2.s_rready = 1;
        for (int i = 0; i < 5; i++) begin
            bus2.s_araddr = 32'h0000_A000 + 32'(i * 4); bus2.s_arvalid = 1;
            cyc();
            bus2.s_arvalid = 0;
            chk("sat_rvalid", bus2.s_rvalid, 1);
            chk("sat_rdcnt", rd_cnt2, (i < 3) ? i + 1 : 3);
            cyc();
        end
        chk("sat_last", last_addr2, 32'h0000_A010);

        // Reset while rvalid is high aborts the response.
        bus2.s_rready = 0; bus2.s_arvalid = 1;
        cyc();
        bus2.s_arvalid = 0;
        chk("rr_rvalid_before", bus2.s_rvalid, 1);
        rst2 = 1;
        #1;
        chk("rr_arready_in_rst", bus2.s_arready, 0);
        cyc();
        chk("rr_rvalid", bus2.s_rvalid, 0);
        chk("rr_rdcnt", rd_cnt2, 0);
        chk("rr_wrcnt", wr_cnt2, 0);
        chk("rr_last", last_addr2, 0);
        rst2 = 0;
        #1;
        chk("rr_arready_back", bus2.s_arready, 1);

        // Reset also aborts a write with only W accepted: no B follows.
        bus.s_bready = 1; bus.s_wvalid = 1;
        cyc();
        bus.s_wvalid = 0;
        rst = 1;
        cyc();
        rst = 0;
        bus.s_awaddr = 32'h0000_B000; bus.s_awvalid = 1;
        cyc();
        bus.s_awvalid = 0;
        chk("ra_no_bvalid", bus.s_bvalid, 0);
        chk("ra_wready_open", bus.s_wready, 1);
        chk("ra_wrcnt", wr_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
